// File: rtl/signal_capture_ring_buffer.sv
// signal_capture_ring_buffer: captures a sample stream into on-chip RAM as a one-shot or continuous ring,
// with an Avalon-MM data slave for RAM access and a four-register CSR slave for control.
module signal_capture_ring_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_chipselect,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W-1:0]   s_readdata,
    input  logic [1:0]          csr_address,
    input  logic                csr_write,
    input  logic                csr_read,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    input  logic                st_valid,
    input  logic [DATA_W-1:0]   st_data,
    output logic                st_ready
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t state, state_n;
    logic ctrl_en, ctrl_mode, done_flag, wrapped;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0] count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic ctrl_wr, clr, start, stop, accept, last;
    logic [31:0] csr_mux;
    always_comb begin
        ctrl_wr = csr_write && csr_address == 2'd0;
        clr = ctrl_wr && csr_writedata[2];
        start = ctrl_wr && !clr && csr_writedata[0] && !ctrl_en && state == IDLE;
        stop = ctrl_wr && !csr_writedata[0] && ctrl_en;
        accept = st_valid && st_ready;
        last = accept && &wr_ptr;
        state_n = state;
        if (clr) state_n = IDLE;
        else if (state == IDLE) state_n = start ? CAPTURE : IDLE;
        else if (stop) state_n = IDLE;
        else if (state == CAPTURE && last && !ctrl_mode) state_n = DONE;
        csr_mux = csr_address == 2'd0 ? {30'd0, ctrl_mode, ctrl_en} :
                  csr_address == 2'd1 ? {29'd0, wrapped, done_flag, state == CAPTURE} :
                  csr_address == 2'd2 ? 32'(wr_ptr) : 32'(count);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            st_ready <= 1'b0;
            ctrl_en <= 1'b0;
            ctrl_mode <= 1'b0;
            done_flag <= 1'b0;
            wrapped <= 1'b0;
            wr_ptr <= '0;
            count <= '0;
            csr_readdata <= '0;
            s_readdata <= '0;
        end else begin
            state <= state_n;
            st_ready <= state_n == CAPTURE;
            if (ctrl_wr) begin
                ctrl_en <= csr_writedata[0] && !clr;
                ctrl_mode <= csr_writedata[1];
            end
            if (clr || start) begin
                wr_ptr <= '0;
                count <= '0;
                done_flag <= 1'b0;
                wrapped <= 1'b0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                count <= count == FULL ? count : count + (ADDR_W+1)'(1);
                if (last && !ctrl_mode) done_flag <= 1'b1;
                if (last && ctrl_mode) wrapped <= 1'b1;
            end
            if (csr_read) csr_readdata <= csr_mux;
            if (s_chipselect && s_read) s_readdata <= mem[s_address];
        end
    end
    // The stream owns the write port for the whole capture; host writes only land outside it.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= st_data;
        else if (s_chipselect && s_write && state != CAPTURE)
            for (int b = 0; b < DATA_W/8; b++)
                if (s_byteenable[b]) mem[s_address][b*8 +: 8] <= s_writedata[b*8 +: 8];
    end
endmodule
